// File: rtl/cpu_controller_pkg.sv
// Shared definitions for the 8-bit RISC CPU controller: widths, opcode encodings
// and the names of the eight sequencer phases.
package cpu_controller_pkg;

  localparam int OPC_W   = 3;
  localparam int PHASE_W = 3;

  typedef enum logic [OPC_W-1:0] {
    OP_HLT = 3'd0,
    OP_SKZ = 3'd1,
    OP_ADD = 3'd2,
    OP_AND = 3'd3,
    OP_XOR = 3'd4,
    OP_LDA = 3'd5,
    OP_STO = 3'd6,
    OP_JMP = 3'd7
  } opcode_t;

  typedef enum logic [PHASE_W-1:0] {
    PH_INST_ADDR  = 3'd0,
    PH_INST_FETCH = 3'd1,
    PH_INST_LOAD  = 3'd2,
    PH_IDLE       = 3'd3,
    PH_OP_ADDR    = 3'd4,
    PH_OP_FETCH   = 3'd5,
    PH_ALU_OP     = 3'd6,
    PH_STORE      = 3'd7
  } phase_t;

endpackage

// File: rtl/cpu_controller_phase_counter.sv
// Free-running 3-bit phase counter for the CPU sequencer; wraps 7 -> 0 and
// freezes on its current value while hold_i is high.
module cpu_controller_phase_counter
  import cpu_controller_pkg::*;
(
  input  logic               clock,
  input  logic               reset,
  input  logic               hold_i,
  output logic [PHASE_W-1:0] count_o
);

  logic [PHASE_W-1:0] count_q;
  logic [PHASE_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (!hold_i) begin
      count_d = count_q + 3'd1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/cpu_controller.sv
// Central sequencer of the 8-bit RISC CPU: steps through eight phases per
// instruction and decodes every datapath strobe from phase, opcode and zero.
module cpu_controller
  import cpu_controller_pkg::*;
(
  input  logic               clock,
  input  logic               reset,
  input  logic [OPC_W-1:0]   opcode,
  input  logic               zero,
  output logic               sel,
  output logic               rd,
  output logic               ld_ir,
  output logic               inc_pc,
  output logic               ld_pc,
  output logic               ld_ac,
  output logic               wr,
  output logic               data_e,
  output logic               halt,
  output logic               halted,
  output logic [PHASE_W-1:0] phase
);

  logic [PHASE_W-1:0] phaseCount;
  logic               halted_q;
  logic               halted_d;
  logic               aluOp;
  logic               isHlt;
  logic               isSkz;
  logic               isSto;
  logic               isJmp;

  // Hold uses the next-state flag so the counter freezes on the very edge
  // that latches HLT, leaving phase parked at OP_ADDR.
  cpu_controller_phase_counter uPhaseCounter (
    .clock   (clock),
    .reset   (reset),
    .hold_i  (halted_d),
    .count_o (phaseCount)
  );

  always_comb begin
    isHlt = (opcode == OP_HLT);
    isSkz = (opcode == OP_SKZ);
    isSto = (opcode == OP_STO);
    isJmp = (opcode == OP_JMP);
    aluOp = (opcode == OP_ADD) || (opcode == OP_AND) ||
            (opcode == OP_XOR) || (opcode == OP_LDA);
    halted_d = halted_q || ((phaseCount == PH_OP_ADDR) && isHlt);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      halted_q <= 1'b0;
    end else begin
      halted_q <= halted_d;
    end
  end

  always_comb begin
    sel    = 1'b0;
    rd     = 1'b0;
    ld_ir  = 1'b0;
    inc_pc = 1'b0;
    ld_pc  = 1'b0;
    ld_ac  = 1'b0;
    wr     = 1'b0;
    data_e = 1'b0;
    halt   = 1'b0;
    if (halted_q) begin
      halt = 1'b1;
    end else begin
      case (phase_t'(phaseCount))
        PH_INST_ADDR: begin
          sel = 1'b1;
        end
        PH_INST_FETCH: begin
          sel = 1'b1;
          rd  = 1'b1;
        end
        PH_INST_LOAD, PH_IDLE: begin
          sel   = 1'b1;
          rd    = 1'b1;
          ld_ir = 1'b1;
        end
        PH_OP_ADDR: begin
          inc_pc = 1'b1;
          halt   = isHlt;
        end
        PH_OP_FETCH: begin
          rd = aluOp;
        end
        PH_ALU_OP: begin
          rd     = aluOp;
          inc_pc = isSkz && zero;
          ld_pc  = isJmp;
          data_e = isSto;
        end
        PH_STORE: begin
          rd     = aluOp;
          ld_ac  = aluOp;
          ld_pc  = isJmp;
          inc_pc = isJmp;
          data_e = isSto;
          wr     = isSto;
        end
        default: begin
          sel = 1'b0;
        end
      endcase
    end
  end

  assign halted = halted_q;
  assign phase  = phaseCount;

endmodule

// File: tb/tb_cpu_controller.sv
// Directed self-checking bench for cpu_controller: walks each instruction class
// through its eight phases and compares strobes against hand-built tables.
module tb_cpu_controller;

  logic       clock = 1'b0;
  logic       reset;
  logic [2:0] opcode;
  logic       zero;
  logic       sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, wr, data_e, halt, halted;
  logic [2:0] phase;

  int testsRun    = 0;
  int testsFailed = 0;

  // Strobe vector order: sel rd ld_ir inc_pc ld_pc ld_ac wr data_e halt
  logic [8:0] strobes;
  assign strobes = {sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, wr, data_e, halt};

  always #5 clock = ~clock;

  cpu_controller dut (
    .clock  (clock),
    .reset  (reset),
    .opcode (opcode),
    .zero   (zero),
    .sel    (sel),
    .rd     (rd),
    .ld_ir  (ld_ir),
    .inc_pc (inc_pc),
    .ld_pc  (ld_pc),
    .ld_ac  (ld_ac),
    .wr     (wr),
    .data_e (data_e),
    .halt   (halt),
    .halted (halted),
    .phase  (phase)
  );

  // Reset is released on a falling edge so phase 0 is observable until the next rise.
  task automatic applyReset();
    reset = 1'b1;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
  endtask

  // Runs one instruction from phase 0 and checks phase, strobes and halted per phase.
  task automatic runInstruction(input string name, input logic [2:0] op, input logic z,
                                input logic [8:0] exp [8]);
    applyReset();
    opcode = op;
    zero   = z;
    for (int p = 0; p < 8; p++) begin
      testsRun++;
      if (phase !== p[2:0] || strobes !== exp[p] || halted !== 1'b0) begin
        testsFailed++;
        $display("[TB] FAIL %s phase%0d: phase=%0d strobes=%b halted=%b, expected phase=%0d strobes=%b halted=0",
                 name, p, phase, strobes, halted, p, exp[p]);
      end
      @(negedge clock);
    end
    testsRun++;
    if (phase !== 3'd0) begin
      testsFailed++;
      $display("[TB] FAIL %s wrap: phase=%0d, expected 0", name, phase);
    end
  endtask

  task automatic test_reset();
    applyReset();
    opcode = 3'd6;
    zero   = 1'b0;
    repeat (5) @(negedge clock);
    testsRun++;
    if (phase !== 3'd5) begin
      testsFailed++;
      $display("[TB] FAIL reset_setup: phase=%0d, expected 5", phase);
    end
    #2 reset = 1'b1;
    #1;
    testsRun++;
    if (phase !== 3'd0 || strobes !== 9'b100000000 || halted !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL reset_async: phase=%0d strobes=%b halted=%b, expected phase=0 strobes=100000000 halted=0",
               phase, strobes, halted);
    end
    reset = 1'b0;
  endtask

  task automatic test_add();
    logic [8:0] exp [8];
    exp = '{9'b100000000, 9'b110000000, 9'b111000000, 9'b111000000,
            9'b000100000, 9'b010000000, 9'b010000000, 9'b010001000};
    runInstruction("add", 3'd2, 1'b0, exp);
  endtask

  task automatic test_sto();
    logic [8:0] exp [8];
    exp = '{9'b100000000, 9'b110000000, 9'b111000000, 9'b111000000,
            9'b000100000, 9'b000000000, 9'b000000010, 9'b000000110};
    runInstruction("sto", 3'd6, 1'b1, exp);
  endtask

  task automatic test_skz();
    logic [8:0] expZ [8];
    logic [8:0] expNz [8];
    expZ  = '{9'b100000000, 9'b110000000, 9'b111000000, 9'b111000000,
              9'b000100000, 9'b000000000, 9'b000100000, 9'b000000000};
    expNz = '{9'b100000000, 9'b110000000, 9'b111000000, 9'b111000000,
              9'b000100000, 9'b000000000, 9'b000000000, 9'b000000000};
    runInstruction("skz_zero", 3'd1, 1'b1, expZ);
    runInstruction("skz_nonzero", 3'd1, 1'b0, expNz);
  endtask

  task automatic test_jmp();
    logic [8:0] exp [8];
    exp = '{9'b100000000, 9'b110000000, 9'b111000000, 9'b111000000,
            9'b000100000, 9'b000000000, 9'b000010000, 9'b000110000};
    runInstruction("jmp", 3'd7, 1'b1, exp);
  endtask

  task automatic test_hlt();
    applyReset();
    opcode = 3'd0;
    zero   = 1'b0;
    repeat (4) @(negedge clock);
    testsRun++;
    if (phase !== 3'd4 || strobes !== 9'b000100001 || halted !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL hlt_phase4: phase=%0d strobes=%b halted=%b, expected phase=4 strobes=000100001 halted=0",
               phase, strobes, halted);
    end
    for (int c = 0; c < 20; c++) begin
      @(negedge clock);
      opcode = 3'(c);
      zero   = c[0];
      #1;
      testsRun++;
      if (phase !== 3'd4 || strobes !== 9'b000000001 || halted !== 1'b1) begin
        testsFailed++;
        $display("[TB] FAIL hlt_hold%0d: phase=%0d strobes=%b halted=%b, expected phase=4 strobes=000000001 halted=1",
                 c, phase, strobes, halted);
      end
    end
    #2 reset = 1'b1;
    #1;
    testsRun++;
    if (phase !== 3'd0 || strobes !== 9'b100000000 || halted !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL hlt_release: phase=%0d strobes=%b halted=%b, expected phase=0 strobes=100000000 halted=0",
               phase, strobes, halted);
    end
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    testsRun++;
    if (phase !== 3'd1) begin
      testsFailed++;
      $display("[TB] FAIL hlt_resume: phase=%0d, expected 1", phase);
    end
  endtask

  initial begin
    reset  = 1'b1;
    opcode = 3'd0;
    zero   = 1'b0;
    test_reset();
    test_add();
    test_sto();
    test_skz();
    test_jmp();
    test_hlt();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
